or_accum16: RTL and testbench



---
 rtl/or_accum16.sv | 140 ++++++++++++++
 tb/tb_or_accum16.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_accum16.sv
// or_accum16: OR-accumulates a burst of COUNT words from the 16-bit OR stage
// and presents the accumulated mask on a registered valid/ready output.
// Optional build macro OR_ACCUM16_PARITY_EN adds out_parity, the XOR-reduction
// of the captured result word, registered alongside out_data.
// Legal configuration: 1 <= COUNT <= 255 and 2**CNT_W > COUNT.
module or_accum16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned COUNT = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] beat_cnt
`ifdef OR_ACCUM16_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
`ifdef OR_ACCUM16_PARITY_EN
    logic               parity_q,    parity_d;
`endif

    logic               accept;
    logic               xfer;
    logic               last_beat;
    logic [WIDTH-1:0]   acc_or;

    // Handshake decode and the running OR including the word on the input.
    always_comb begin
        in_ready  = (state_q == ST_ACC) && !clear;
        accept    = in_valid && in_ready;
        xfer      = out_valid_q && out_ready;
        last_beat = (beat_cnt_q == LAST_BEAT);
        acc_or    = acc_q | in_data;
    end

    // Next-state logic: clear overrides everything, then ACC/HOLD behaviour.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef OR_ACCUM16_PARITY_EN
        parity_d    = parity_q;
`endif
        if (clear) begin
            // A pending result is dropped but out_data (and parity) keep their value.
            state_d     = ST_ACC;
            acc_d       = '0;
            beat_cnt_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (last_beat) begin
                            out_data_d  = acc_or;
                            out_valid_d = 1'b1;
`ifdef OR_ACCUM16_PARITY_EN
                            parity_d    = ^acc_or;
`endif
                            acc_d       = '0;
                            beat_cnt_d  = '0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d       = acc_or;
                            beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // No bypass: in_ready only returns the cycle after transfer.
                    if (xfer) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // State and datapath registers, asynchronously reset to an empty burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef OR_ACCUM16_PARITY_EN
    // Parity of the captured result, updated only when out_data is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_or_accum16.sv
module tb_or_accum16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  beat_cnt;

    logic        c1_valid;
    logic        c1_in_ready;
    logic [15:0] c1_data;
    logic        c1_out_valid;
    logic        c1_out_ready;
    logic [15:0] c1_out_data;
    logic [7:0]  c1_beat_cnt;

`ifdef OR_ACCUM16_PARITY_EN
    logic        out_parity;
    logic        c1_out_parity;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    or_accum16 #(.WIDTH(16), .COUNT(4), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt)
`ifdef OR_ACCUM16_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    or_accum16 #(.WIDTH(16), .COUNT(1), .CNT_W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .in_valid  (c1_valid),
        .in_ready  (c1_in_ready),
        .in_data   (c1_data),
        .out_valid (c1_out_valid),
        .out_ready (c1_out_ready),
        .out_data  (c1_out_data),
        .beat_cnt  (c1_beat_cnt)
`ifdef OR_ACCUM16_PARITY_EN
        ,
        .out_parity(c1_out_parity)
`endif
    );

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        oready;
        logic        clr;
        logic        exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_cnt;
        logic [15:0] exp_od;
        logic        push;
        logic [15:0] push_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic valid, input logic [15:0] data,
                                input logic oready, input logic clr,
                                input logic exp_ready, input logic exp_ov,
                                input logic [7:0] exp_cnt, input logic [15:0] exp_od,
                                input logic push, input logic [15:0] push_data);
        vec_t v;
        v.valid = valid;  v.data = data;  v.oready = oready;  v.clr = clr;
        v.exp_ready = exp_ready;  v.exp_ov = exp_ov;
        v.exp_cnt = exp_cnt;  v.exp_od = exp_od;
        v.push = push;  v.push_data = push_data;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge, check mid-cycle, advance.
    task automatic apply(input int idx, input vec_t v);
        logic [15:0] e;
        in_valid  = v.valid;
        in_data   = v.data;
        out_ready = v.oready;
        clear     = v.clr;
        @(negedge clk);
        chk("in_ready",  idx, 32'(in_ready),  32'(v.exp_ready));
        chk("out_valid", idx, 32'(out_valid), 32'(v.exp_ov));
        chk("beat_cnt",  idx, 32'(beat_cnt),  32'(v.exp_cnt));
        chk("out_data",  idx, 32'(out_data),  32'(v.exp_od));
        if (v.push) sb_q.push_back(v.push_data);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", idx, 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", idx, 32'(out_data), 32'(e));
`ifdef OR_ACCUM16_PARITY_EN
                chk("sb_parity", idx, 32'(out_parity), 32'(^e));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;  clear = 1'b0;  in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
        c1_valid = 1'b0;  c1_data = '0;  c1_out_ready = 1'b0;

        //            valid data      ord clr  rdy ov cnt   od        push data
        // basic burst, out_ready high
        tbl.push_back(mk(1, 16'h0001, 1, 0,  1, 0, 8'd0, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0010, 1, 0,  1, 0, 8'd1, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0100, 1, 0,  1, 0, 8'd2, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 16'h1000, 1, 0,  1, 0, 8'd3, 16'h0000, 1, 16'h1111));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  0, 1, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  1, 0, 8'd0, 16'h1111, 0, 16'h0));
        // backpressure: extra beats offered while HOLD must not be consumed
        tbl.push_back(mk(1, 16'h0001, 0, 0,  1, 0, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0010, 0, 0,  1, 0, 8'd1, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0100, 0, 0,  1, 0, 8'd2, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h1000, 0, 0,  1, 0, 8'd3, 16'h1111, 1, 16'h1111));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 16'hFFFF, 0, 0,  0, 1, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'hFFFF, 1, 0,  0, 1, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  1, 0, 8'd0, 16'h1111, 0, 16'h0));
        // clear mid-burst
        tbl.push_back(mk(1, 16'hFF00, 1, 0,  1, 0, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h00FF, 1, 0,  1, 0, 8'd1, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'hFFFF, 1, 1,  0, 0, 8'd2, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0003, 1, 0,  1, 0, 8'd0, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0003, 1, 0,  1, 0, 8'd1, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0003, 1, 0,  1, 0, 8'd2, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0003, 1, 0,  1, 0, 8'd3, 16'h1111, 1, 16'h0003));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  0, 1, 8'd0, 16'h0003, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  1, 0, 8'd0, 16'h0003, 0, 16'h0));
        // clear in HOLD discards the result but keeps out_data
        tbl.push_back(mk(1, 16'h0A00, 0, 0,  1, 0, 8'd0, 16'h0003, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0000, 0, 0,  1, 0, 8'd1, 16'h0003, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0000, 0, 0,  1, 0, 8'd2, 16'h0003, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0000, 0, 0,  1, 0, 8'd3, 16'h0003, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 0, 1,  0, 1, 8'd0, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 0, 0,  1, 0, 8'd0, 16'h0A00, 0, 16'h0));
        // idle data changes without in_valid have no effect
        tbl.push_back(mk(0, 16'hFFFF, 1, 0,  1, 0, 8'd0, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(0, 16'h1234, 1, 0,  1, 0, 8'd0, 16'h0A00, 0, 16'h0));
        // burst with a gap cycle
        tbl.push_back(mk(1, 16'h0002, 1, 0,  1, 0, 8'd0, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(0, 16'hFFFF, 1, 0,  1, 0, 8'd1, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0004, 1, 0,  1, 0, 8'd1, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0008, 1, 0,  1, 0, 8'd2, 16'h0A00, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0010, 1, 0,  1, 0, 8'd3, 16'h0A00, 1, 16'h001E));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  0, 1, 8'd0, 16'h001E, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  1, 0, 8'd0, 16'h001E, 0, 16'h0));
        // back-to-back bursts at minimum period, in_valid held high
        tbl.push_back(mk(1, 16'h0001, 1, 0,  1, 0, 8'd0, 16'h001E, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0002, 1, 0,  1, 0, 8'd1, 16'h001E, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0004, 1, 0,  1, 0, 8'd2, 16'h001E, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0008, 1, 0,  1, 0, 8'd3, 16'h001E, 1, 16'h000F));
        tbl.push_back(mk(1, 16'h8000, 1, 0,  0, 1, 8'd0, 16'h000F, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0100, 1, 0,  1, 0, 8'd0, 16'h000F, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0200, 1, 0,  1, 0, 8'd1, 16'h000F, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0400, 1, 0,  1, 0, 8'd2, 16'h000F, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0800, 1, 0,  1, 0, 8'd3, 16'h000F, 1, 16'h0F00));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  0, 1, 8'd0, 16'h0F00, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 0,  1, 0, 8'd0, 16'h0F00, 0, 16'h0));

        // reset and idle
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_in_ready",  0, 32'(in_ready),  32'd1);
        chk("rst_out_data",  0, 32'(out_data),  32'h0000);
        chk("rst_beat_cnt",  0, 32'(beat_cnt),  32'd0);
`ifdef OR_ACCUM16_PARITY_EN
        chk("rst_parity",    0, 32'(out_parity), 32'd0);
`endif

        foreach (tbl[i]) apply(i, tbl[i]);
        chk("sb_drained", 0, 32'(sb_q.size()), 32'd0);

        // async reset while a result is held
        out_ready = 1'b0;  clear = 1'b0;  in_valid = 1'b1;
        in_data = 16'hA000;  @(posedge clk); #1;
        in_data = 16'h0B00;  @(posedge clk); #1;
        in_data = 16'h00C0;  @(posedge clk); #1;
        in_data = 16'h000D;  @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_out_valid", 1, 32'(out_valid), 32'd1);
        chk("hold_out_data",  1, 32'(out_data),  32'hABCD);
        chk("hold_in_ready",  1, 32'(in_ready),  32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 1, 32'(out_valid), 32'd0);
        chk("arst_out_data",  1, 32'(out_data),  32'h0000);
        chk("arst_beat_cnt",  1, 32'(beat_cnt),  32'd0);
        chk("arst_in_ready",  1, 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // async reset mid-burst loses the partial accumulation
        out_ready = 1'b1;  in_valid = 1'b1;
        in_data = 16'h00F0;  @(posedge clk); #1;
        in_data = 16'h0F00;  @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_beat_cnt", 2, 32'(beat_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_arst_cnt", 2, 32'(beat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;  in_data = 16'h0001;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("post_rst_valid", 3, 32'(out_valid), 32'd1);
        chk("post_rst_data",  3, 32'(out_data),  32'h0001);
        @(posedge clk); #1;
        chk("post_rst_xfer",  3, 32'(out_valid), 32'd0);
        chk("post_rst_ready", 3, 32'(in_ready),  32'd1);

        // COUNT == 1: every accepted beat is a complete burst
        c1_out_ready = 1'b1;  c1_valid = 1'b1;  c1_data = 16'h0007;
        #1;
        chk("c1_in_ready0", 4, 32'(c1_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("c1_out_valid0", 4, 32'(c1_out_valid), 32'd1);
        chk("c1_out_data0",  4, 32'(c1_out_data),  32'h0007);
        chk("c1_beat_cnt0",  4, 32'(c1_beat_cnt),  32'd0);
        chk("c1_in_ready1",  4, 32'(c1_in_ready),  32'd0);
`ifdef OR_ACCUM16_PARITY_EN
        chk("c1_parity0",    4, 32'(c1_out_parity), 32'd1);
`endif
        c1_data = 16'h0003;
        @(posedge clk); #1;
        chk("c1_out_valid1", 5, 32'(c1_out_valid), 32'd0);
        chk("c1_in_ready2",  5, 32'(c1_in_ready),  32'd1);
        chk("c1_out_data1",  5, 32'(c1_out_data),  32'h0007);
        @(posedge clk); #1;
        c1_valid = 1'b0;
        chk("c1_out_valid2", 6, 32'(c1_out_valid), 32'd1);
        chk("c1_out_data2",  6, 32'(c1_out_data),  32'h0003);
`ifdef OR_ACCUM16_PARITY_EN
        chk("c1_parity1",    6, 32'(c1_out_parity), 32'd0);
`endif
        @(posedge clk); #1;
        chk("c1_out_valid3", 7, 32'(c1_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
